// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus per-key debounce FSM for active-low keys; LONG_PRESS_EN adds a long-press pulse.
// Latency: key_value/key_flag change TIME_20MS+3 cycles after key_in settles; key_long TIME_LONG cycles after key_flag.
// Backpressure: none; key_flag/key_long are single-cycle pulses that the consumer must take when asserted.
module key_debounce #(
    parameter int KEY_W     = 4,
    parameter int TIME_20MS = 1_000_000,
    parameter int TIME_LONG = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_value,
    output logic [KEY_W-1:0] key_flag,
    output logic [KEY_W-1:0] key_long
);

    localparam int CNT_W = (TIME_20MS > 1) ? $clog2(TIME_20MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME_20MS - 1);

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = (TIME_LONG > 1) ? $clog2(TIME_LONG) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIME_LONG - 1);
`endif

    if (TIME_20MS < 2 || TIME_LONG < 2) begin : g_param_check
        $error("key_debounce: TIME_20MS and TIME_LONG must both be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_F = 2'd1,
        DOWN    = 2'd2,
        REL_F   = 2'd3
    } state_t;

    logic [KEY_W-1:0] key_meta;
    logic [KEY_W-1:0] key_s;

    // Reset to 1 (released) so a held key must re-qualify through a full window.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta <= '1;
            key_s    <= '1;
        end else begin
            key_meta <= key_in;
            key_s    <= key_meta;
        end
    end

    for (genvar k = 0; k < KEY_W; k++) begin : g_key
        state_t           state_q;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_nxt;
        logic             value_q;
        logic             value_nxt;
        logic             flag_q;
        logic             flag_nxt;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                value_q <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                state_q <= state_nxt;
                cnt_q   <= cnt_nxt;
                value_q <= value_nxt;
                flag_q  <= flag_nxt;
            end
        end

        // Any disagreement with the filtered direction restarts the window from zero.
        always_comb begin
            state_nxt = state_q;
            cnt_nxt   = cnt_q;
            value_nxt = value_q;
            flag_nxt  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!key_s[k]) begin
                        state_nxt = PRESS_F;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_F: begin
                    if (key_s[k]) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_nxt = DOWN;
                        cnt_nxt   = '0;
                        value_nxt = 1'b1;
                        flag_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_s[k]) begin
                        state_nxt = REL_F;
                        cnt_nxt   = '0;
                    end
                end
                REL_F: begin
                    if (!key_s[k]) begin
                        state_nxt = DOWN;
                        cnt_nxt   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        value_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    value_nxt = 1'b0;
                end
            endcase
        end

        assign key_value[k] = value_q;
        assign key_flag[k]  = flag_q;

`ifdef LONG_PRESS_EN
        logic [HOLD_W-1:0] hold_q;
        logic [HOLD_W-1:0] hold_nxt;
        logic              done_q;
        logic              done_nxt;
        logic              long_q;
        logic              long_nxt;

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q <= '0;
                done_q <= 1'b0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_nxt;
                done_q <= done_nxt;
                long_q <= long_nxt;
            end
        end

        // Only a fresh press clears the hold count; a REL_F bounce back to DOWN resumes it.
        always_comb begin
            hold_nxt = hold_q;
            done_nxt = done_q;
            long_nxt = 1'b0;
            if (state_q == PRESS_F && state_nxt == DOWN) begin
                hold_nxt = '0;
                done_nxt = 1'b0;
            end else if (state_q == DOWN && !done_q) begin
                if (hold_q == HOLD_LAST) begin
                    long_nxt = 1'b1;
                    done_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_q + 1'b1;
                end
            end
        end

        assign key_long[k] = long_q;
`else
        assign key_long[k] = 1'b0;
`endif
    end

endmodule
